// File: rtl/bist_sig_analyzer.sv
// BIST signature analyzer: 16-bit MISR (x^16+x^12+x^5+1) with a golden-signature verdict FSM.
// Optional build macro BIST_CYCLE_CHECK_EN adds a compacted-sample counter that must equal EXP_CYCLES for pass.
module bist_sig_analyzer #(
  parameter logic [15:0] GOLDEN     = 16'h0000,
  parameter logic [15:0] SEED       = 16'hFFFF,
  parameter logic [15:0] EXP_CYCLES = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        running,
  input  logic        bist_end,
  input  logic [15:0] cut_resp,
  output logic [15:0] signature,
  output logic        done,
  output logic        pass,
  output logic        fail
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPACT = 2'd1;
  localparam logic [1:0] S_CHECK   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // One MISR shift: feedback of the MSB into taps 0, 5 and 12, each stage XORed with its data bit.
  function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [15:0] d);
    logic [15:0] n;
    n[0] = sig[15] ^ d[0];
    for (int i = 1; i < 16; i++) begin
      n[i] = sig[i-1] ^ d[i] ^ (((i == 5) || (i == 12)) ? sig[15] : 1'b0);
    end
    return n;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [15:0] sig_q, sig_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        match_s;

`ifdef BIST_CYCLE_CHECK_EN
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc_s;

  assign cnt_inc_s = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
  assign match_s   = (sig_q == GOLDEN) && (cnt_q == EXP_CYCLES);
`else
  assign match_s   = (sig_q == GOLDEN);
`endif

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
`ifdef BIST_CYCLE_CHECK_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        // A new run always starts from SEED, including directly out of DONE.
        if (running) begin
          sig_d   = misr_next(SEED, cut_resp);
          state_d = S_COMPACT;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
`ifdef BIST_CYCLE_CHECK_EN
          cnt_d   = 16'd1;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_COMPACT: begin
        if (running) begin
          sig_d = misr_next(sig_q, cut_resp);
`ifdef BIST_CYCLE_CHECK_EN
          cnt_d = cnt_inc_s;
`endif
        end else begin
          sig_d = sig_q;
        end
        if (bist_end) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_COMPACT;
        end
      end
      S_CHECK: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        pass_d  = match_s;
        fail_d  = ~match_s;
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

`ifdef BIST_CYCLE_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign signature = sig_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_bist_sig_analyzer.sv
// Scoreboard bench for bist_sig_analyzer: three instances with different GOLDEN values share one stimulus stream.
module tb_bist_sig_analyzer;

  function automatic logic [15:0] tb_step(input logic [15:0] s, input logic [15:0] d);
    tb_step = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
  endfunction

  function automatic logic [15:0] three_zero_sig();
    logic [15:0] s;
    s = 16'hFFFF;
    for (int k = 0; k < 3; k++) s = tb_step(s, 16'h0000);
    return s;
  endfunction

  localparam logic [15:0] G_A = 16'hEFDF;
  localparam logic [15:0] G_B = 16'h1234;
  localparam logic [15:0] G_C = three_zero_sig();

  logic        clk = 1'b0;
  logic        reset, running, bist_end;
  logic [15:0] cut_resp;
  logic [15:0] sig_a, sig_b, sig_c;
  logic        done_a, pass_a, fail_a;
  logic        done_b, pass_b, fail_b;
  logic        done_c, pass_c, fail_c;

  bist_sig_analyzer #(.GOLDEN(G_A), .SEED(16'hFFFF), .EXP_CYCLES(16'd4)) dut_a (
    .clk(clk), .reset(reset), .running(running), .bist_end(bist_end), .cut_resp(cut_resp),
    .signature(sig_a), .done(done_a), .pass(pass_a), .fail(fail_a));
  bist_sig_analyzer #(.GOLDEN(G_B), .SEED(16'hFFFF), .EXP_CYCLES(16'd4)) dut_b (
    .clk(clk), .reset(reset), .running(running), .bist_end(bist_end), .cut_resp(cut_resp),
    .signature(sig_b), .done(done_b), .pass(pass_b), .fail(fail_b));
  bist_sig_analyzer #(.GOLDEN(G_C), .SEED(16'hFFFF), .EXP_CYCLES(16'd4)) dut_c (
    .clk(clk), .reset(reset), .running(running), .bist_end(bist_end), .cut_resp(cut_resp),
    .signature(sig_c), .done(done_c), .pass(pass_c), .fail(fail_c));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sig;
    logic        pa;
    logic        pb;
    logic        pc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_sig;
  logic [15:0] m_cnt;
  logic        m_fresh;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_sample(input logic [15:0] d);
    if (m_fresh) begin
      m_sig   = 16'hFFFF;
      m_cnt   = 16'd0;
      m_fresh = 1'b0;
    end
    m_sig = tb_step(m_sig, d);
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic sample(input logic [15:0] d);
    running  = 1'b1;
    cut_resp = d;
    @(posedge clk); #1;
    running  = 1'b0;
    model_sample(d);
    chk("sample_sig", sig_a, m_sig);
    chk("done_clear", {done_a, done_b, done_c}, 16'd0);
  endtask

  task automatic pause(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk("pause_hold", sig_a, m_sig);
    end
  endtask

  task automatic finish_run(input logic with_sample, input logic [15:0] d);
    exp_t e;
    int   n;
    logic cnt_ok;
    bist_end = 1'b1;
    running  = with_sample;
    cut_resp = d;
    @(posedge clk); #1;
    bist_end = 1'b0;
    running  = 1'b0;
    if (with_sample) model_sample(d);
`ifdef BIST_CYCLE_CHECK_EN
    cnt_ok = (m_cnt == 16'd4);
`else
    cnt_ok = 1'b1;
`endif
    e.sig = m_sig;
    e.pa  = (m_sig == G_A) && cnt_ok;
    e.pb  = (m_sig == G_B) && cnt_ok;
    e.pc  = (m_sig == G_C) && cnt_ok;
    sb_q.push_back(e);
    m_fresh = 1'b1;
    chk("end_sig", sig_a, m_sig);
    chk("done_in_check", {15'd0, done_a}, 16'd0);
    n = 0;
    while (!done_a && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_latency", 16'(n), 16'd1);
    e = sb_q.pop_front();
    chk("verdict_sig", sig_a, e.sig);
    chk("verdict_a", {done_a, pass_a, fail_a}, {13'd0, 1'b1, e.pa, ~e.pa});
    chk("verdict_b", {done_b, pass_b, fail_b}, {13'd0, 1'b1, e.pb, ~e.pb});
    chk("verdict_c", {done_c, pass_c, fail_c}, {13'd0, 1'b1, e.pc, ~e.pc});
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_reset_sig", sig_a, 16'hFFFF);
    chk("async_reset_flags", {done_a, pass_a, fail_a}, 16'd0);
    @(posedge clk); #1;
    reset   = 1'b0;
    m_fresh = 1'b1;
    m_sig   = 16'hFFFF;
    @(posedge clk); #1;
    chk("post_reset_sig", sig_a, 16'hFFFF);
    chk("post_reset_flags", {done_a, pass_a, fail_a}, 16'd0);
  endtask

  initial begin
    reset    = 1'b1;
    running  = 1'b0;
    bist_end = 1'b0;
    cut_resp = 16'h0000;
    m_sig    = 16'hFFFF;
    m_cnt    = 16'd0;
    m_fresh  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sig", sig_a, 16'hFFFF);
    chk("reset_flags", {done_a, pass_a, fail_a}, 16'd0);
    reset = 1'b0;

    // Single zero sample from FFFF must give EFDF: instance a matches, b mismatches.
    sample(16'h0000);
    chk("single_sample_ref", sig_a, 16'hEFDF);
    finish_run(1'b0, 16'h0000);

    // Verdict held through idle cycles, bist_end in DONE ignored.
    bist_end = 1'b1;
    @(posedge clk); #1;
    bist_end = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_b", {done_b, pass_b, fail_b}, 16'b101);
    chk("hold_sig", sig_a, 16'hEFDF);

    // Reseed out of DONE, pause, then finish.
    sample(16'hA5A5);
    pause(3);
    sample(16'h1234);
    finish_run(1'b0, 16'h0000);

    // Final sample compacted together with bist_end.
    sample(16'h0F0F);
    sample(16'h8001);
    finish_run(1'b1, 16'h7E57);

    // Reset from DONE, then an IDLE bist_end pulse must not produce a verdict.
    pulse_reset();
    bist_end = 1'b1;
    @(posedge clk); #1;
    bist_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_pulse_done", {done_a, done_b, done_c}, 16'd0);
    chk("idle_pulse_sig", sig_a, 16'hFFFF);

    // Abandon a run mid-COMPACT.
    sample(16'hBEEF);
    sample(16'hCAFE);
    pulse_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("abandon_done", {done_a, done_b, done_c}, 16'd0);

    // Sample-count runs against instance c.
    for (int k = 0; k < 3; k++) sample(16'h0000);
    finish_run(1'b0, 16'h0000);
    for (int k = 0; k < 3; k++) sample(16'h0000);
    sample(tb_step(G_C, 16'h0000) ^ G_C);
    chk("four_sample_sig", sig_c, G_C);
    finish_run(1'b0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
